// File: rtl/zigbee_pkg.sv
// Shared receive-path definitions: nibble/word geometry and the packer's state type.
package zigbee_pkg;

  localparam int NIB_W   = 4;
  localparam int NIBBLES = 8;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam int WORD_W  = NIB_W * NIBBLES;

  // FILL: no complete word held; HOLD: outData carries a complete word.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

endpackage

// File: rtl/nibble_packer.sv
// Packs 4-bit symbol nibbles (nibble k -> bits [4k+3:4k]) into 32-bit words,
// with valid/ready on both sides and one nibble per cycle sustained.
module nibble_packer
  import zigbee_pkg::*;
(
  input  logic                inClk,
  input  logic                inRstN,
  input  logic [NIB_W-1:0]    inData,
  input  logic                inValid,
  output logic                outInReady,
  input  logic                inClear,
  output logic [WORD_W-1:0]   outData,
  output logic                outValid,
  input  logic                inReady,
  output logic [IDX_W-1:0]    outCount
);

  pack_state_t         state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [WORD_W-1:0]   fill_reg, fill_next;
  logic [WORD_W-1:0]   out_reg, out_next;

  logic last_nib;
  logic accept;
  logic nib_xfer;
  logic word_xfer;
  logic complete;

  assign last_nib = (idx_reg == IDX_W'(NIBBLES - 1));

  // A partial word keeps filling behind a held word; only the completing
  // nibble has to wait for the held word to leave.
  assign accept    = !inClear && ((state_reg == FILL) || inReady || !last_nib);
  assign nib_xfer  = inValid && accept;
  assign word_xfer = (state_reg == HOLD) && inReady && !inClear;
  assign complete  = nib_xfer && last_nib;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign fill_next[gi*NIB_W +: NIB_W] =
        (nib_xfer && (idx_reg == IDX_W'(gi))) ? inData : fill_reg[gi*NIB_W +: NIB_W];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    out_next   = out_reg;

    if (inClear) begin
      state_next = FILL;
      idx_next   = '0;
    end else begin
      if (nib_xfer) begin
        idx_next = last_nib ? '0 : idx_reg + IDX_W'(1);
      end
      // fill_next already carries the completing nibble, so the word is whole.
      if (complete) begin
        out_next   = fill_next;
        state_next = HOLD;
      end else if (word_xfer) begin
        state_next = FILL;
      end
    end
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_reg <= FILL;
      idx_reg   <= '0;
      fill_reg  <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      fill_reg  <= fill_next;
      out_reg   <= out_next;
    end
  end

  assign outInReady = accept;
  assign outData    = out_reg;
  assign outValid   = (state_reg == HOLD);
  assign outCount   = idx_reg;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed and randomized bench for nibble_packer against a queue-based
// model of accepted nibbles and the held word.
module tb_nibble_packer;
  import zigbee_pkg::*;

  logic              inClk = 1'b0;
  logic              inRstN = 1'b0;
  logic [NIB_W-1:0]  inData = '0;
  logic              inValid = 1'b0;
  logic              outInReady;
  logic              inClear = 1'b0;
  logic [WORD_W-1:0] outData;
  logic              outValid;
  logic              inReady = 1'b0;
  logic [IDX_W-1:0]  outCount;

  nibble_packer dut (
    .inClk      (inClk),
    .inRstN     (inRstN),
    .inData     (inData),
    .inValid    (inValid),
    .outInReady (outInReady),
    .inClear    (inClear),
    .outData    (outData),
    .outValid   (outValid),
    .inReady    (inReady),
    .outCount   (outCount)
  );

  always #5 inClk = ~inClk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model: nibbles accepted into the current word, plus the held word.
  logic [NIB_W-1:0]  m_part[$];
  bit                m_held = 1'b0;
  logic [WORD_W-1:0] m_word = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(outValid), 32'(m_held));
    chk("out_data", outData, m_word);
    chk("out_count", 32'(outCount), 32'(m_part.size()));
  endtask

  task automatic model_reset();
    m_part.delete();
    m_held = 1'b0;
    m_word = '0;
  endtask

  task automatic cycle(input logic v, input logic [NIB_W-1:0] d, input logic r, input logic c);
    bit rdy, wx, nx, done;
    inValid = v;
    inData  = d;
    inReady = r;
    inClear = c;
    #1;
    rdy = !c && (!m_held || r || (m_part.size() != NIBBLES - 1));
    chk("in_ready", 32'(outInReady), 32'(rdy));
    wx   = m_held && r && !c;
    nx   = v && rdy;
    done = 1'b0;
    if (wx) $display("word out %h", outData);
    if (c) begin
      m_part.delete();
      m_held = 1'b0;
    end else begin
      if (nx) begin
        m_part.push_back(d);
        if (m_part.size() == NIBBLES) begin
          m_word = '0;
          for (int k = 0; k < NIBBLES; k++) m_word = m_word | (32'(m_part[k]) << (4 * k));
          m_part.delete();
          done = 1'b1;
        end
      end
      if (done) m_held = 1'b1;
      else if (wx) m_held = 1'b0;
    end
    @(posedge inClk);
    #1;
    check_outputs();
  endtask

  initial begin
    model_reset();
    #12;
    inRstN = 1'b1;
    @(posedge inClk);
    #1;
    check_outputs();
    chk("reset_ready", 32'(outInReady), 32'd1);
    chk("reset_data", outData, 32'h0);

    // Nibbles 1..8, word visible one cycle after the eighth.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0);
    chk("word_87654321", outData, 32'h87654321);
    chk("word1_valid", 32'(outValid), 32'd1);
    chk("word1_count", 32'(outCount), 32'd0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Sixteen nibbles back to back.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 4'(i), 1'b1, 1'b0);
      if (i == 7) chk("word_76543210", outData, 32'h76543210);
    end
    chk("word_fedcba98", outData, 32'hFEDCBA98);
    chk("b2b_valid", 32'(outValid), 32'd1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Held word with downstream stalled; the completing nibble waits.
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    for (int i = 8; i < 15; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    chk("stall_count", 32'(outCount), 32'd7);
    chk("stall_data", outData, 32'h76543210);
    inValid = 1'b1; inData = 4'hF; inReady = 1'b0; inClear = 1'b0;
    #1;
    chk("stall_ready_low", 32'(outInReady), 32'd0);
    cycle(1'b1, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, 1'b1, 1'b0);
    chk("replace_valid", 32'(outValid), 32'd1);
    chk("replace_data", outData, 32'hFEDCBA98);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Clear after a partial word.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'hA, 1'b1, 1'b0);
    chk("word_aaaaaaaa", outData, 32'hAAAAAAAA);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Clear with a held word and a simultaneous nibble.
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'h5, 1'b0, 1'b0);
    cycle(1'b1, 4'h9, 1'b0, 1'b1);
    chk("clear_valid", 32'(outValid), 32'd0);
    chk("clear_count", 32'(outCount), 32'd0);
    for (int i = 1; i <= 8; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0);
    chk("after_clear_word", outData, 32'h87654321);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a word.
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'hE, 1'b1, 1'b0);
    chk("pre_reset_count", 32'(outCount), 32'd5);
    inValid = 1'b0;
    #2;
    inRstN = 1'b0;
    #1;
    model_reset();
    chk("async_valid", 32'(outValid), 32'd0);
    chk("async_data", outData, 32'h0);
    chk("async_count", 32'(outCount), 32'd0);
    chk("async_ready", 32'(outInReady), 32'd1);
    #1;
    inRstN = 1'b1;
    @(posedge inClk);
    #1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'(12 - i), 1'b1, 1'b0);
    chk("post_reset_word", outData, 32'h56789ABC);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
